// File: rtl/matmul2x2_core_if.sv
// Start/done handshake plus a/b read ports and the res write port of the 2x2 matrix multiply core.
interface matmul2x2_core_if #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 16
);
  logic              ap_start;
  logic              ap_done;
  logic              ap_idle;
  logic              ap_ready;
  logic [1:0]        a_address0;
  logic              a_ce0;
  logic [DATA_W-1:0] a_q0;
  logic [1:0]        b_address0;
  logic              b_ce0;
  logic [DATA_W-1:0] b_q0;
  logic [1:0]        res_address0;
  logic              res_ce0;
  logic              res_we0;
  logic [RES_W-1:0]  res_d0;

  modport master (
    output ap_start, a_q0, b_q0,
    input  ap_done, ap_idle, ap_ready, a_address0, a_ce0, b_address0, b_ce0,
    input  res_address0, res_ce0, res_we0, res_d0
  );

  modport slave (
    input  ap_start, a_q0, b_q0,
    output ap_done, ap_idle, ap_ready, a_address0, a_ce0, b_address0, b_ce0,
    output res_address0, res_ce0, res_we0, res_d0
  );
endinterface

// File: rtl/matmul2x2_core.sv
// 2x2 signed matrix multiply: reads a and b element by element, then writes the four
// dot products of res in row-major order. All interface outputs are registered.
module matmul2x2_core #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  matmul2x2_core_if.slave  bus
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam int EXT_W  = (RES_W > SUM_W) ? RES_W : SUM_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                   state_r;
  logic [2:0]               cnt_r;
  logic signed [DATA_W-1:0] a_r    [4];
  logic signed [DATA_W-1:0] b_r    [4];
  logic signed [DATA_W-1:0] a_next [4];
  logic signed [DATA_W-1:0] b_next [4];
  logic [1:0]               cap_idx;
  logic [1:0]               wr_idx;
  logic [RES_W-1:0]         wr_data;

  // Signed x0*y0 + x1*y1 at full precision, then wrapped to RES_W bits.
  function automatic logic [RES_W-1:0] dot2(
    input logic signed [DATA_W-1:0] x0,
    input logic signed [DATA_W-1:0] x1,
    input logic signed [DATA_W-1:0] y0,
    input logic signed [DATA_W-1:0] y1
  );
    logic signed [PROD_W-1:0] p0;
    logic signed [PROD_W-1:0] p1;
    logic signed [SUM_W-1:0]  s;
    logic signed [EXT_W-1:0]  e;
    p0 = PROD_W'(x0) * PROD_W'(y0);
    p1 = PROD_W'(x1) * PROD_W'(y1);
    s  = SUM_W'(p0) + SUM_W'(p1);
    e  = EXT_W'(s);
    return e[RES_W-1:0];
  endfunction

  // Operand capture view: read data lands one cycle after its address, so READ cnt k fills slot k-1.
  // The result for the first WRITE cycle is formed from this view, which already holds a[3]/b[3].
  always_comb begin
    cap_idx = cnt_r[1:0] - 2'd1;
    a_next  = a_r;
    b_next  = b_r;
    if (state_r == READ && cnt_r != 3'd0) begin
      a_next[cap_idx] = $signed(bus.a_q0);
      b_next[cap_idx] = $signed(bus.b_q0);
    end else begin
      a_next = a_r;
      b_next = b_r;
    end
  end

  // Index and data of the res element written in the coming cycle (i = idx[1], j = idx[0]).
  always_comb begin
    wr_idx  = (state_r == WRITE) ? (cnt_r[1:0] + 2'd1) : 2'd0;
    wr_data = dot2(a_next[{wr_idx[1], 1'b0}], a_next[{wr_idx[1], 1'b1}],
                   b_next[{1'b0, wr_idx[0]}], b_next[{1'b1, wr_idx[0]}]);
  end

  // Control FSM; outputs are set on the same edge as the state they belong to.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_r          <= IDLE;
      cnt_r            <= 3'd0;
      bus.ap_done      <= 1'b0;
      bus.ap_ready     <= 1'b0;
      bus.ap_idle      <= 1'b1;
      bus.a_ce0        <= 1'b0;
      bus.a_address0   <= 2'd0;
      bus.b_ce0        <= 1'b0;
      bus.b_address0   <= 2'd0;
      bus.res_ce0      <= 1'b0;
      bus.res_we0      <= 1'b0;
      bus.res_address0 <= 2'd0;
      bus.res_d0       <= {RES_W{1'b0}};
    end else begin
      a_r              <= a_next;
      b_r              <= b_next;
      bus.ap_done      <= 1'b0;
      bus.ap_ready     <= 1'b0;
      bus.ap_idle      <= 1'b0;
      bus.a_ce0        <= 1'b0;
      bus.a_address0   <= 2'd0;
      bus.b_ce0        <= 1'b0;
      bus.b_address0   <= 2'd0;
      bus.res_ce0      <= 1'b0;
      bus.res_we0      <= 1'b0;
      bus.res_address0 <= 2'd0;
      bus.res_d0       <= {RES_W{1'b0}};
      case (state_r)
        IDLE: begin
          if (bus.ap_start) begin
            state_r   <= READ;
            cnt_r     <= 3'd0;
            bus.a_ce0 <= 1'b1;
            bus.b_ce0 <= 1'b1;
          end else begin
            bus.ap_idle <= 1'b1;
          end
        end
        READ: begin
          if (cnt_r == 3'd4) begin
            state_r          <= WRITE;
            cnt_r            <= 3'd0;
            bus.res_ce0      <= 1'b1;
            bus.res_we0      <= 1'b1;
            bus.res_address0 <= wr_idx;
            bus.res_d0       <= wr_data;
          end else begin
            cnt_r <= cnt_r + 3'd1;
            if (cnt_r != 3'd3) begin
              bus.a_ce0      <= 1'b1;
              bus.a_address0 <= cnt_r[1:0] + 2'd1;
              bus.b_ce0      <= 1'b1;
              bus.b_address0 <= cnt_r[1:0] + 2'd1;
            end
          end
        end
        WRITE: begin
          if (cnt_r == 3'd3) begin
            state_r      <= DONE;
            cnt_r        <= 3'd0;
            bus.ap_done  <= 1'b1;
            bus.ap_ready <= 1'b1;
          end else begin
            cnt_r            <= cnt_r + 3'd1;
            bus.res_ce0      <= 1'b1;
            bus.res_we0      <= 1'b1;
            bus.res_address0 <= wr_idx;
            bus.res_d0       <= wr_data;
          end
        end
        DONE: begin
          state_r     <= IDLE;
          cnt_r       <= 3'd0;
          bus.ap_idle <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= 3'd0;
          bus.ap_idle <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul2x2_core.sv
// Directed-plus-random bench for matmul2x2_core: memory models on the a/b ports and a
// cycle-by-cycle comparison of every output against a matrix-product reference.
module tb_matmul2x2_core;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  logic signed [7:0] mem_a [4];
  logic signed [7:0] mem_b [4];

  always #5 clk = ~clk;

  matmul2x2_core_if #(.DATA_W(8), .RES_W(16)) bus ();

  matmul2x2_core #(.DATA_W(8), .RES_W(16)) dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus)
  );

  // Read-only memories with one cycle of latency; data is unknown when not enabled.
  always @(posedge clk) begin
    if (bus.a_ce0) bus.a_q0 <= mem_a[bus.a_address0];
    else           bus.a_q0 <= {8{1'bx}};
    if (bus.b_ce0) bus.b_q0 <= mem_b[bus.b_address0];
    else           bus.b_q0 <= {8{1'bx}};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // res[i][j] = sum over k of a[i][k]*b[k][j], wrapped to 16 bits.
  function automatic logic [15:0] ref_res(input int idx);
    int i;
    int j;
    int acc;
    i   = idx / 2;
    j   = idx % 2;
    acc = 0;
    for (int k = 0; k < 2; k++) acc += int'(mem_a[i*2+k]) * int'(mem_b[k*2+j]);
    return 16'(acc);
  endfunction

  function automatic logic [12:0] obs_ctrl();
    return {bus.ap_idle, bus.ap_done, bus.ap_ready, bus.a_ce0, bus.a_address0,
            bus.b_ce0, bus.b_address0, bus.res_ce0, bus.res_we0, bus.res_address0};
  endfunction

  // Expected control outputs in cycle k after start was sampled (k=11 is the IDLE cycle).
  function automatic logic [12:0] exp_ctrl(input int k, input int abort_k);
    logic       idle;
    logic       done;
    logic       ce;
    logic       we;
    logic [1:0] ra;
    logic [1:0] wa;
    idle = 1'b0; done = 1'b0; ce = 1'b0; we = 1'b0; ra = 2'd0; wa = 2'd0;
    if (abort_k != 0 && k > abort_k) idle = 1'b1;
    else if (k >= 1 && k <= 4) begin ce = 1'b1; ra = 2'(k - 1); end
    else if (k >= 6 && k <= 9) begin we = 1'b1; wa = 2'(k - 6); end
    else if (k == 10) done = 1'b1;
    else if (k == 11) idle = 1'b1;
    return {idle, done, done, ce, ra, ce, ra, we, we, wa};
  endfunction

  task automatic set_mem(input int a0, a1, a2, a3, b0, b1, b2, b3);
    mem_a[0] = 8'(a0); mem_a[1] = 8'(a1); mem_a[2] = 8'(a2); mem_a[3] = 8'(a3);
    mem_b[0] = 8'(b0); mem_b[1] = 8'(b1); mem_b[2] = 8'(b2); mem_b[3] = 8'(b3);
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 4; i++) begin
      mem_a[i] = 8'($urandom_range(0, 255));
      mem_b[i] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic idle_check(input string name, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      check($sformatf("%s_idle%0d", name, c), 32'(obs_ctrl()), 32'(13'h1000));
    end
  endtask

  // One transaction starting at the next edge; optional held start, spurious start, reset abort.
  task automatic txn(input string name, input bit hold, input int spur_k, input int abort_k);
    logic [15:0] exp_r [4];
    for (int i = 0; i < 4; i++) exp_r[i] = ref_res(i);
    bus.ap_start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check($sformatf("%s_ctrl_c%0d", name, k), 32'(obs_ctrl()), 32'(exp_ctrl(k, abort_k)));
      if (k >= 6 && k <= 9 && !(abort_k != 0 && k > abort_k))
        check($sformatf("%s_res%0d", name, k - 6), 32'(bus.res_d0), 32'(exp_r[k-6]));
      if (k == 1 && !hold) bus.ap_start = 1'b0;
      if (spur_k != 0 && k == spur_k) bus.ap_start = 1'b1;
      if (spur_k != 0 && k == spur_k + 1) bus.ap_start = 1'b0;
      if (abort_k != 0 && k == abort_k) rst = 1'b1;
      if (abort_k != 0 && k == abort_k + 1) rst = 1'b0;
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.ap_start = 1'b1;
    set_mem(0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("reset_ctrl%0d", c), 32'(obs_ctrl()), 32'(13'h1000));
      check($sformatf("reset_d0_%0d", c), 32'(bus.res_d0), 32'd0);
    end
    rst          = 1'b0;
    bus.ap_start = 1'b0;
    idle_check("post_reset", 2);

    set_mem(1, 2, 3, 4, 5, 6, 7, 8);
    txn("basic", 1'b0, 0, 0);
    idle_check("basic", 1);

    set_mem(-128, -128, 0, 0, -128, 0, -128, 0);
    txn("wrap", 1'b0, 0, 0);

    rand_mem(); txn("b2b0", 1'b1, 0, 0);
    rand_mem(); txn("b2b1", 1'b1, 0, 0);
    rand_mem(); txn("b2b2", 1'b0, 0, 0);

    rand_mem(); txn("spur", 1'b0, 2, 0);
    idle_check("spur", 12);

    rand_mem(); txn("abort", 1'b0, 0, 7);
    idle_check("abort", 3);
    rand_mem(); txn("fresh", 1'b0, 0, 0);

    for (int r = 0; r < 4; r++) begin
      rand_mem();
      txn($sformatf("rand%0d", r), 1'b0, 0, 0);
    end
    idle_check("final", 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
